// File: rtl/sram_responder_if.sv
// Valid/ready request and response bus between a core memory port and sram_responder.
interface sram_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wen;
  logic [31:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/sram_responder.sv
// Single-outstanding SRAM responder: word read / byte-masked write after LATENCY cycles.
// Define SRAM_RAND_DELAY_EN to add 0..7 LFSR-driven extra wait cycles per request.
module sram_responder #(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned LATENCY   = 1
) (
  input logic             clk,
  input logic             rst,
  sram_responder_if.slave bus
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [8:0]      cnt_reg;
  logic            err_reg;
  logic [AW-1:0]   idx_reg;
  logic            ok_reg;
  logic            wen_reg;
  logic [31:0]     wdata_reg;
  logic [3:0]      wmask_reg;
  logic [31:0]     rdata;
  logic [2:0]      extra;
  logic            accept;
  logic            commit;
  logic [32:0]     offset;
  logic            addr_ok;
  logic            unused_bits;

  // A borrow into bit 32 marks addresses below BASE_ADDR as out of range.
  assign offset      = {1'b0, bus.req_addr} - {1'b0, BASE_ADDR};
  assign addr_ok     = (offset < SPAN);
  assign accept      = (state_reg == IDLE) && bus.req_valid;
  assign commit      = (state_reg == WAIT) && (cnt_reg == '0);
  assign unused_bits = ^{bus.req_wmask[7:4], offset[32:AW+2], offset[1:0]};

`ifdef SRAM_RAND_DELAY_EN
  logic [15:0] lfsr_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_reg <= 16'hACE1;
    end else begin
      lfsr_reg <= {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign extra = lfsr_reg[2:0];
`else
  assign extra = 3'd0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.req_valid)    state_next = WAIT;
      WAIT:    if (cnt_reg == '0)    state_next = RESP;
      RESP:    if (bus.resp_ready)   state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    case (state_reg)
      IDLE:    bus.req_ready  = rst;
      RESP:    bus.resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else if (accept) begin
      cnt_reg <= 9'(LATENCY - 1) + 9'(extra);
    end else if (state_reg == WAIT) begin
      if (cnt_reg != '0) begin
        cnt_reg <= cnt_reg - 9'd1;
      end else begin
        err_reg <= !ok_reg;
      end
    end
  end

  // Request fields are only consumed after acceptance, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_reg   <= offset[AW+1:2];
      ok_reg    <= addr_ok;
      wen_reg   <= bus.req_wen;
      wdata_reg <= bus.req_wdata;
      wmask_reg <= bus.req_wmask[3:0];
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bank
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_reg;

      always_ff @(posedge clk) begin
        if (rst && commit && ok_reg && wen_reg && wmask_reg[gi]) begin
          mem[idx_reg] <= wdata_reg[gi*8 +: 8];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          rd_reg <= '0;
        end else if (commit) begin
          rd_reg <= (ok_reg && !wen_reg) ? mem[idx_reg] : 8'h00;
        end
      end

      assign rdata[gi*8 +: 8] = rd_reg;
    end
  endgenerate

  assign bus.resp_rdata = rdata;
  assign bus.resp_err   = err_reg;
endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: three instances (LATENCY 1, 3, 4) checked against a cycle-count model.
module tb_sram_responder;
  localparam int NDUT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [NDUT];
  logic        req_valid  [NDUT];
  logic [31:0] req_addr   [NDUT];
  logic        req_wen    [NDUT];
  logic [31:0] req_wdata  [NDUT];
  logic [7:0]  req_wmask  [NDUT];
  logic        resp_ready [NDUT];
  logic        req_ready  [NDUT];
  logic        resp_valid [NDUT];
  logic [31:0] resp_rdata [NDUT];
  logic        resp_err   [NDUT];

  generate
    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      sram_responder_if bus ();
      assign bus.req_valid  = req_valid[gi];
      assign bus.req_addr   = req_addr[gi];
      assign bus.req_wen    = req_wen[gi];
      assign bus.req_wdata  = req_wdata[gi];
      assign bus.req_wmask  = req_wmask[gi];
      assign bus.resp_ready = resp_ready[gi];
      assign req_ready[gi]  = bus.req_ready;
      assign resp_valid[gi] = bus.resp_valid;
      assign resp_rdata[gi] = bus.resp_rdata;
      assign resp_err[gi]   = bus.resp_err;

      sram_responder #(
        .DEPTH    (4096),
        .BASE_ADDR(32'h8000_0000),
        .LATENCY  ((gi == 0) ? 1 : ((gi == 1) ? 3 : 4))
      ) dut (
        .clk(clk),
        .rst(rst[gi]),
        .bus(bus)
      );
    end
  endgenerate

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  // Model: a transaction accepted at edge N answers from edge N+L; memory as a sparse word map.
  bit          pend     [NDUT];
  bit          resp_m   [NDUT];
  bit          rst_seen [NDUT];
  int          acc      [NDUT];
  bit          m_wen    [NDUT];
  logic [31:0] m_addr   [NDUT];
  logic [31:0] m_wdata  [NDUT];
  logic [7:0]  m_mask   [NDUT];
  logic [31:0] exp_rd   [NDUT];
  bit          exp_err  [NDUT];
  bit [31:0]   mm       [int];

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  function automatic void model_commit(int k);
    longint    off;
    int        key;
    bit [31:0] w;
    off = longint'(m_addr[k]) - longint'(32'h8000_0000);
    if (off < 0 || off >= 4 * 4096) begin
      exp_rd[k]  = 32'h0;
      exp_err[k] = 1'b1;
      return;
    end
    key        = k * 65536 + int'(off / 4);
    w          = mm.exists(key) ? mm[key] : 32'h0;
    exp_err[k] = 1'b0;
    if (m_wen[k]) begin
      for (int b = 0; b < 4; b++) begin
        if (m_mask[k][b]) w[8*b +: 8] = m_wdata[k][8*b +: 8];
      end
      mm[key]   = w;
      exp_rd[k] = 32'h0;
    end else begin
      exp_rd[k] = w;
    end
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %08h want %08h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    for (int k = 0; k < NDUT; k++) begin
      if (!rst[k]) begin
        pend[k]     = 1'b0;
        resp_m[k]   = 1'b0;
        rst_seen[k] = 1'b1;
      end else begin
        rst_seen[k] = 1'b0;
        if (resp_m[k]) begin
          if (resp_ready[k]) begin
            resp_m[k] = 1'b0;
            pend[k]   = 1'b0;
          end
        end else if (pend[k]) begin
          if (cyc == acc[k] + lat_of(k)) begin
            model_commit(k);
            resp_m[k] = 1'b1;
          end
        end else if (req_valid[k]) begin
          pend[k]    = 1'b1;
          acc[k]     = cyc;
          m_wen[k]   = req_wen[k];
          m_addr[k]  = req_addr[k];
          m_wdata[k] = req_wdata[k];
          m_mask[k]  = req_wmask[k];
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (cyc > 0) begin
      for (int k = 0; k < NDUT; k++) begin
        check($sformatf("dut%0d req_ready", k), req_ready[k], rst[k] && !pend[k]);
        check($sformatf("dut%0d resp_valid", k), resp_valid[k], resp_m[k]);
        if (resp_m[k]) begin
          check($sformatf("dut%0d resp_rdata", k), resp_rdata[k], exp_rd[k]);
          check($sformatf("dut%0d resp_err", k), resp_err[k], exp_err[k]);
        end
        if (rst_seen[k]) begin
          check($sformatf("dut%0d reset rdata", k), resp_rdata[k], 32'h0);
          check($sformatf("dut%0d reset err", k), resp_err[k], 32'h0);
        end
      end
    end
  end

  task automatic wait_accept(input int k, output bit ok, output int acc_c);
    bit r;
    ok    = 1'b0;
    acc_c = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      r = req_ready[k];
      @(posedge clk);
      #1;
      if (r) begin
        ok    = 1'b1;
        acc_c = cyc;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_miss++;
      $display("FAIL dut%0d accept timeout: got req_ready=0 for 50 cycles, want 1", k);
    end
  endtask

  task automatic xfer(input int k, input bit wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [7:0] mask, input int hold,
                      output logic [31:0] rd, output bit er, output int lt);
    bit ok;
    bit got;
    int acc_c;
    rd            = 32'h0;
    er            = 1'b0;
    lt            = -1;
    req_addr[k]   = addr;
    req_wen[k]    = wen;
    req_wdata[k]  = wdata;
    req_wmask[k]  = mask;
    req_valid[k]  = 1'b1;
    resp_ready[k] = (hold == 0);
    wait_accept(k, ok, acc_c);
    req_valid[k] = 1'b0;
    if (!ok) return;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (resp_valid[k]) begin
        got = 1'b1;
        lt  = cyc - acc_c;
        rd  = resp_rdata[k];
        er  = resp_err[k];
        break;
      end
    end
    if (!got) begin
      n_vec++;
      n_miss++;
      $display("FAIL dut%0d response timeout: got resp_valid=0 for 300 cycles, want 1", k);
      @(posedge clk);
      #1;
      return;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check($sformatf("dut%0d stall resp_valid", k), resp_valid[k], 32'h1);
      check($sformatf("dut%0d stall req_ready", k), req_ready[k], 32'h0);
    end
    resp_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[k] = 1'b0;
    if (hold > 0) begin
      @(negedge clk);
      check($sformatf("dut%0d release resp_valid", k), resp_valid[k], 32'h0);
      check($sformatf("dut%0d release req_ready", k), req_ready[k], 32'h1);
      @(posedge clk);
      #1;
    end
    $display("dut%0d %s addr=%08h wdata=%08h mask=%02h -> rdata=%08h err=%0b latency=%0d",
             k, wen ? "WR" : "RD", addr, wdata, mask, rd, er, lt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, want summary before 200000 time units");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    bit          er;
    bit          ok;
    int          lt;
    int          acc_c;

    for (int k = 0; k < NDUT; k++) begin
      rst[k]        = 1'b0;
      req_valid[k]  = 1'b1;
      req_addr[k]   = 32'h8000_0010;
      req_wen[k]    = 1'b0;
      req_wdata[k]  = 32'h0;
      req_wmask[k]  = 8'h0;
      resp_ready[k] = 1'b1;
    end
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        check($sformatf("dut%0d in-reset req_ready", k), req_ready[k], 32'h0);
        check($sformatf("dut%0d in-reset resp_valid", k), resp_valid[k], 32'h0);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) rst[k] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("dut%0d post-reset req_ready", k), req_ready[k], 32'h1);
      req_valid[k] = 1'b0;
    end
    @(posedge clk);
    #1;

    // LATENCY=1: full write, read back, byte masks
    xfer(0, 1'b1, 32'h8000_0010, 32'hDEADBEEF, 8'h0F, 0, rd, er, lt);
    check("L1 write latency", lt, 1);
    check("L1 write err", er, 0);
    xfer(0, 1'b0, 32'h8000_0010, 32'h0, 8'h0, 0, rd, er, lt);
    check("L1 read rdata", rd, 32'hDEADBEEF);
    check("L1 read latency", lt, 1);
    xfer(0, 1'b1, 32'h8000_0010, 32'h11223344, 8'h05, 0, rd, er, lt);
    xfer(0, 1'b0, 32'h8000_0010, 32'h0, 8'h0, 0, rd, er, lt);
    check("mask 05 rdata", rd, 32'hDE22BE44);
    xfer(0, 1'b1, 32'h8000_0010, 32'hFFFFFFFF, 8'h00, 0, rd, er, lt);
    check("mask 00 write err", er, 0);
    xfer(0, 1'b0, 32'h8000_0010, 32'h0, 8'h0, 0, rd, er, lt);
    check("mask 00 rdata", rd, 32'hDE22BE44);
    xfer(0, 1'b1, 32'h8000_0010, 32'hAABBCCDD, 8'hF3, 0, rd, er, lt);
    xfer(0, 1'b0, 32'h8000_0010, 32'h0, 8'h0, 0, rd, er, lt);
    check("mask F3 rdata", rd, 32'hDE22CCDD);

    // Range boundaries
    xfer(0, 1'b1, 32'h8000_0000, 32'h01234567, 8'h0F, 0, rd, er, lt);
    xfer(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 8'h0, 0, rd, er, lt);
    check("below base err", er, 1);
    check("below base rdata", rd, 32'h0);
    xfer(0, 1'b0, 32'h8000_4000, 32'h0, 8'h0, 0, rd, er, lt);
    check("above top err", er, 1);
    check("above top rdata", rd, 32'h0);
    xfer(0, 1'b1, 32'h8000_4000, 32'hFFFFFFFF, 8'h0F, 0, rd, er, lt);
    check("above top write err", er, 1);
    xfer(0, 1'b0, 32'h8000_0000, 32'h0, 8'h0, 0, rd, er, lt);
    check("word 0 unchanged", rd, 32'h01234567);
    xfer(0, 1'b1, 32'h8000_3FFF, 32'h13579BDF, 8'h0F, 0, rd, er, lt);
    check("last word write err", er, 0);
    xfer(0, 1'b0, 32'h8000_3FFC, 32'h0, 8'h0, 0, rd, er, lt);
    check("last word rdata", rd, 32'h13579BDF);

    // LATENCY=3 with 5 stalled response cycles
    xfer(1, 1'b1, 32'h8000_0008, 32'h5A5AA5A5, 8'h0F, 0, rd, er, lt);
    check("L3 write latency", lt, 3);
    xfer(1, 1'b0, 32'h8000_0008, 32'h0, 8'h0, 5, rd, er, lt);
    check("L3 read latency", lt, 3);
    check("L3 read rdata", rd, 32'h5A5AA5A5);

    // LATENCY=4: reset while a write waits discards it
    xfer(2, 1'b1, 32'h8000_0020, 32'h0BADF00D, 8'h0F, 0, rd, er, lt);
    check("L4 write latency", lt, 4);
    req_addr[2]  = 32'h8000_0020;
    req_wen[2]   = 1'b1;
    req_wdata[2] = 32'hFFFFFFFF;
    req_wmask[2] = 8'h0F;
    req_valid[2] = 1'b1;
    wait_accept(2, ok, acc_c);
    req_valid[2] = 1'b0;
    @(posedge clk);
    #1;
    rst[2] = 1'b0;
    @(posedge clk);
    #1;
    rst[2] = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("aborted write resp_valid", resp_valid[2], 32'h0);
    end
    @(posedge clk);
    #1;
    $display("dut2 WR addr=80000020 wdata=ffffffff mask=0f -> aborted by reset");
    xfer(2, 1'b0, 32'h8000_0020, 32'h0, 8'h0, 0, rd, er, lt);
    check("after abort rdata", rd, 32'h0BADF00D);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the core's valid/ready memory requests: serves the instruction-fetch unit or the load/store stage.
- Accepts one request at a time, performs a word-organised read or byte-masked write on an internal array, and returns a response after a programmable latency.
- Holds the response until the requester accepts it, so the core's fetch and memory stages can be exercised with multi-cycle memory.

Parameters:
- DEPTH, 4096, number of 32-bit words in the array (power of two).
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- LATENCY, 1, cycles from request acceptance to resp_valid rising; legal range 1..255.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-low: the block resets on a rising clk edge while rst==0.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_addr  input  32  byte address; bits [1:0] ignored.
- req_wen  input  1  1=write, 0=read.
- req_wdata  input  32  write data.
- req_wmask  input  8  byte enables; bits [3:0] map to bytes 0..3; bits [7:4] ignored.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts response.
- resp_rdata  output  32  read data; 0 for writes and errors.
- resp_err  output  1  address outside [BASE_ADDR, BASE_ADDR+4*DEPTH).

Behaviour:
- Reset values: req_ready=0 during reset, 1 on the first cycle after rst returns high. resp_valid=0, resp_rdata=0, resp_err=0. The FSM goes to IDLE and the latency counter clears. Array contents are not cleared.
- FSM states and transitions:
  - IDLE: req_ready=1. On req_valid & req_ready, latch addr/wen/wdata/wmask and go to WAIT with counter=LATENCY-1.
  - WAIT: req_ready=0. The counter decrements each cycle; at counter==0, go to RESP next edge. With LATENCY=1, WAIT lasts exactly one cycle.
  - RESP: resp_valid=1. resp_rdata and resp_err stay stable until resp_ready is sampled high; then go to IDLE with resp_valid=0 on the next edge.
- Net timing: acceptance at edge N gives resp_valid=1 from edge N+LATENCY.
- Write commit: on the WAIT->RESP edge; each byte i with wmask[i]=1 is replaced. Out-of-range writes change nothing and set resp_err=1.
- Read sampling: on the WAIT->RESP edge, so it returns any write already committed. Out-of-range reads give rdata=0, resp_err=1.
- Index = (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits only after the range check.
- No overlap: req_ready is 0 in WAIT and RESP, so maximum throughput is one transaction per LATENCY+2 cycles (resp_ready held high).
- A request arriving while busy is not dropped; it waits on req_ready.
- Reset mid-transaction returns to IDLE. A write not yet committed is discarded; a committed one persists. No response is issued for the aborted request.
- wmask==0 write: completes normally with no array change and resp_err=0.

Optional Feature:
- SRAM_RAND_DELAY_EN defined:
  - A 16-bit Galois LFSR (seed 16'hACE1 at reset, polynomial x^16+x^14+x^13+x^11+1) advances every cycle.
  - The WAIT count loaded at acceptance is LATENCY-1 + lfsr[2:0], giving 0..7 extra cycles.
  - The IDLE->WAIT transition itself is unchanged.
- Undefined: latency is exactly LATENCY and the LFSR logic is absent.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req_valid=1 -> req_ready=0, resp_valid=0 throughout. The first cycle after rst=1 gives req_ready=1.
- Write then read, LATENCY=1:
  - Write 0x8000_0010, wdata 0xDEADBEEF, wmask 0x0F -> resp_valid one cycle after acceptance, resp_err=0.
  - Read 0x8000_0010 -> rdata 0xDEADBEEF.
- Byte mask:
  - Write 0x8000_0010, wdata 0x11223344, wmask 0x05.
  - Read back -> 0xDE22BE44. A wmask=0x00 write leaves the word unchanged.
- Backpressure, LATENCY=3:
  - Read accepted at cycle 10 -> resp_valid rises at cycle 13.
  - Hold resp_ready=0 for 5 cycles -> rdata stable and req_ready=0 throughout.
  - resp_ready=1 -> resp_valid=0 and req_ready=1 next cycle.
- Out of range: read 0x7FFF_FFFC and 0x8000_4000 (DEPTH=4096) -> resp_err=1, rdata=0; a write to 0x8000_4000 leaves word 0 unchanged.
- Reset mid-operation, LATENCY=4: drop rst=0 in WAIT after a write to 0x8000_0020 -> no response; a later read of 0x8000_0020 returns the prior value.
